sync_fifo_gen: RTL and testbench
================================

SYNC_FIFO_GEN -- requirements
Module: sync_fifo_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bus width (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; any integer >=2, power of two not required.
REQ-003 SHALL have parameter AF_THRESH, default FIFO_DEPTH-2, almost-full level (1..FIFO_DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost-empty level (0..FIFO_DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL use one clock and a synchronous, active-high reset: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-007 SHALL have W_INC in 1, write request.
REQ-008 SHALL have WR_DATA in DATA_WIDTH, write data.
REQ-009 SHALL have R_INC in 1, read request.
REQ-010 SHALL have CLR_ERR in 1, clears sticky error flags.
REQ-011 SHALL have RD_DATA out DATA_WIDTH, read data.
REQ-012 SHALL have RD_VALID out 1, RD_DATA qualifier.
REQ-013 SHALL have FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY out 1 each, status flags.
REQ-014 SHALL have FILL_LEVEL out CNT_WIDTH = clog2(FIFO_DEPTH+1), occupied entries.
REQ-015 SHALL have OVERFLOW, UNDERFLOW out 1 each, sticky error flags.

Function
REQ-016 Write accepted iff W_INC=1 and FULL=0; data stored at wr_ptr, wr_ptr advances.
REQ-017 Read accepted iff R_INC=1 and EMPTY=0; rd_ptr advances.
REQ-018 Flags sample registered state only: W_INC while FULL is rejected even with a simultaneous accepted read; R_INC while EMPTY is rejected even with a simultaneous accepted write.
REQ-019 Pointers wrap FIFO_DEPTH-1 -> 0 (explicit compare, no power-of-two reliance).
REQ-020 FILL_LEVEL: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; never exceeds FIFO_DEPTH or goes below 0.
REQ-021 All flags registered and consistent with FILL_LEVEL in the same cycle: FULL = (level==FIFO_DEPTH), EMPTY = (level==0), ALMOST_FULL = (level>=AF_THRESH), ALMOST_EMPTY = (level<=AE_THRESH).
REQ-022 FWFT=0: on accepted read, RD_DATA is loaded with the head entry and RD_VALID=1 on the next cycle; otherwise RD_VALID=0 and RD_DATA holds its last value.
REQ-023 FWFT=1: RD_VALID = !EMPTY; RD_DATA = head entry whenever RD_VALID=1; an accepted read pops it and the next entry appears in the following cycle.
REQ-024 OVERFLOW sets on W_INC=1 while FULL=1; UNDERFLOW sets on R_INC=1 while EMPTY=1; both hold until CLR_ERR=1.
REQ-025 A set condition in the same cycle as CLR_ERR wins and the flag stays 1.
REQ-026 Rejected requests SHALL NOT modify memory, pointers, or FILL_LEVEL.

Reset
REQ-027 While RST=1 at a CLK edge: pointers=0, FILL_LEVEL=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, RD_VALID=0, RD_DATA=0, OVERFLOW=0, UNDERFLOW=0.
REQ-028 RST has priority over all requests; a reset mid-operation discards the contents, and requests in the reset cycle are ignored.
REQ-029 Memory array SHALL NOT be reset.

Structure
REQ-030 Shared package SHALL hold the default DATA_WIDTH/FIFO_DEPTH constants, the clog2 function, and the FWFT mode encodings.
REQ-031 Storage SHALL be a sub-module sync_fifo_mem (write port, combinational read at address); pointer/count/flag logic stays in sync_fifo_gen.

Verification
REQ-032 DEPTH=8, FWFT=0: write 0x11..0x18 -> FULL=1, ALMOST_FULL=1 from level 6; 8 reads return 0x11..0x18 in order, one cycle after each R_INC with RD_VALID=1; then EMPTY=1.
REQ-033 DEPTH=5 (non-power-of-two): 12 write/read pairs staggered by 2 -> pointers wrap correctly, data order preserved, FILL_LEVEL never exceeds 5.
REQ-034 Full FIFO, W_INC=R_INC=1 for one cycle -> read accepted, write rejected, FILL_LEVEL=FIFO_DEPTH-1, OVERFLOW=1; CLR_ERR pulse -> OVERFLOW=0.
REQ-035 Empty FIFO, R_INC=W_INC=1 with WR_DATA=0xA5 -> UNDERFLOW=1, level=1; FWFT=1 -> RD_VALID=1, RD_DATA=0xA5 the next cycle.
REQ-036 Level 4, RST=1 for one cycle with W_INC=1 -> level=0, EMPTY=1, all other outputs at reset values; a following read is rejected with UNDERFLOW=1.

Source files
------------

// File: rtl/sync_fifo_gen_pkg.sv
// Shared constants and helpers for the synchronous FIFO: default sizing,
// read-mode encodings and a constant-evaluable ceiling log2.
package sync_fifo_gen_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32'd8;
   localparam int unsigned DEF_FIFO_DEPTH = 32'd8;

   // Read-mode encodings for the FWFT parameter
   localparam int unsigned FWFT_OFF = 32'd0;   // registered read, one-cycle latency
   localparam int unsigned FWFT_ON  = 32'd1;   // head entry always presented

   // Smallest r such that 2**r >= value (clog2(1) = 0)
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd32; i++) begin
         if ((32'd1 << i) < value) begin
            res = i + 32'd1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// FIFO request/response bundle. The slave modport is the FIFO side,
// the master modport is the user driving writes and reads.
interface sync_fifo_gen_if
   import sync_fifo_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
   localparam int unsigned CNT_WIDTH = clog2(FIFO_DEPTH + 32'd1);

   logic                  w_inc;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  r_inc;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_WIDTH-1:0]  fill_level;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  w_inc, wr_data, r_inc, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             fill_level, overflow, underflow
   );

   modport master (
      output w_inc, wr_data, r_inc, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             fill_level, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; occupancy is tracked by the control logic.
module sync_fifo_mem #(
   parameter int unsigned DATA_WIDTH = 32'd8,
   parameter int unsigned DEPTH      = 32'd8,
   parameter int unsigned ADDR_WIDTH = 32'd3
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store write data at the write address when enabled
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_gen.sv
// Synchronous FIFO with arbitrary depth, registered status flags, sticky
// overflow/underflow errors and selectable registered or first-word-fall-through read.
module sync_fifo_gen
   import sync_fifo_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned AF_THRESH  = FIFO_DEPTH - 32'd2,
   parameter int unsigned AE_THRESH  = 32'd2,
   parameter int unsigned FWFT       = FWFT_OFF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   sync_fifo_gen_if.slave   fifo_if
);

   localparam int unsigned PTR_WIDTH = clog2(FIFO_DEPTH);
   localparam int unsigned CNT_WIDTH = clog2(FIFO_DEPTH + 32'd1);
   localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(FIFO_DEPTH - 32'd1);
   localparam logic [CNT_WIDTH-1:0] FULL_LVL  = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] AF_LVL    = CNT_WIDTH'(AF_THRESH);
   localparam logic [CNT_WIDTH-1:0] AE_LVL    = CNT_WIDTH'(AE_THRESH);

   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  level_q, level_d;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  wr_acc_s, rd_acc_s, mem_we_s, bypass_s;
   logic [PTR_WIDTH-1:0]  mem_raddr_s;
   logic [DATA_WIDTH-1:0] mem_rdata_s;

   // Acceptance looks only at registered flags, so a same-cycle pop never frees a full FIFO
   assign wr_acc_s = fifo_if.w_inc & ~full_q;
   assign rd_acc_s = fifo_if.r_inc & ~empty_q;
   assign mem_we_s = wr_acc_s & ~rst_i;

   // In FWFT mode the read port looks ahead to the next head so the output register can load it
   assign mem_raddr_s = (FWFT == FWFT_ON) ? rd_ptr_d : rd_ptr_q;

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (PTR_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (fifo_if.wr_data),
      .raddr_i (mem_raddr_s),
      .rdata_o (mem_rdata_s)
   );

   // Next-state for pointers, level and sticky errors
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (wr_acc_s) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_WIDTH{1'b0}} : wr_ptr_q + PTR_WIDTH'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_WIDTH{1'b0}} : rd_ptr_q + PTR_WIDTH'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_d = level_q + CNT_WIDTH'(1);
         2'b01:   level_d = level_q - CNT_WIDTH'(1);
         default: level_d = level_q;
      endcase

      // A new error event outranks a simultaneous clear
      ovf_d = (fifo_if.w_inc & full_q)  | (ovf_q & ~fifo_if.clr_err);
      udf_d = (fifo_if.r_inc & empty_q) | (udf_q & ~fifo_if.clr_err);
   end

   // Next-state for the read data/valid output registers
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      // The next head is the word being written now when nothing else will remain
      bypass_s   = wr_acc_s &&
                   ((level_q == {CNT_WIDTH{1'b0}}) ||
                    ((level_q == CNT_WIDTH'(1)) && rd_acc_s));

      if (FWFT == FWFT_ON) begin
         if (level_d == {CNT_WIDTH{1'b0}}) begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
         end else if (bypass_s) begin
            rd_data_d  = fifo_if.wr_data;
            rd_valid_d = 1'b1;
         end else begin
            rd_data_d  = mem_rdata_s;
            rd_valid_d = 1'b1;
         end
      end else begin
         if (rd_acc_s) begin
            rd_data_d  = mem_rdata_s;
            rd_valid_d = 1'b1;
         end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
         end
      end
   end

   // State, flag and output registers; reset discards contents by clearing the bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= {PTR_WIDTH{1'b0}};
         rd_ptr_q   <= {PTR_WIDTH{1'b0}};
         level_q    <= {CNT_WIDTH{1'b0}};
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rd_data_q  <= {DATA_WIDTH{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= (level_d == FULL_LVL);
         empty_q    <= (level_d == {CNT_WIDTH{1'b0}});
         afull_q    <= (level_d >= AF_LVL);
         aempty_q   <= (level_d <= AE_LVL);
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign fifo_if.rd_data      = rd_data_q;
   assign fifo_if.rd_valid     = rd_valid_q;
   assign fifo_if.full         = full_q;
   assign fifo_if.empty        = empty_q;
   assign fifo_if.almost_full  = afull_q;
   assign fifo_if.almost_empty = aempty_q;
   assign fifo_if.fill_level   = level_q;
   assign fifo_if.overflow     = ovf_q;
   assign fifo_if.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed bench: instance A is depth 8 with registered read, instance B is
// depth 5 (non-power-of-two) with first-word-fall-through.
module tb_sync_fifo_gen;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   vectors;
   int   miscompares;

   sync_fifo_gen_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) ifa ();
   sync_fifo_gen_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) ifb ();

   sync_fifo_gen #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) dut_a (
      .clk_i   (clk),
      .rst_i   (rst_a),
      .fifo_if (ifa.slave)
   );

   sync_fifo_gen #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1)) dut_b (
      .clk_i   (clk),
      .rst_i   (rst_b),
      .fifo_if (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check_val({tag, "_lvl"},   32'(ifa.fill_level),   32'd0);
      check_val({tag, "_empty"}, 32'(ifa.empty),        32'd1);
      check_val({tag, "_ae"},    32'(ifa.almost_empty), 32'd1);
      check_val({tag, "_full"},  32'(ifa.full),         32'd0);
      check_val({tag, "_af"},    32'(ifa.almost_full),  32'd0);
      check_val({tag, "_vld"},   32'(ifa.rd_valid),     32'd0);
      check_val({tag, "_data"},  32'(ifa.rd_data),      32'd0);
      check_val({tag, "_ovf"},   32'(ifa.overflow),     32'd0);
      check_val({tag, "_udf"},   32'(ifa.underflow),    32'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic       wr;
      logic       rd;
      vectors     = 0;
      miscompares = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.w_inc = 1'b0; ifa.r_inc = 1'b0; ifa.clr_err = 1'b0; ifa.wr_data = 8'h00;
      ifb.w_inc = 1'b0; ifb.r_inc = 1'b0; ifb.clr_err = 1'b0; ifb.wr_data = 8'h00;
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      check_reset_a("a_rst");
      check_val("b_rst_vld",   32'(ifb.rd_valid), 32'd0);
      check_val("b_rst_empty", 32'(ifb.empty),    32'd1);

      // ---------------- Instance A: fill 0x11..0x18 ----------------
      for (int i = 0; i < 8; i++) begin
         ifa.w_inc   = 1'b1;
         ifa.wr_data = 8'(8'h11 + i);
         tick();
         check_val("a_fill_lvl",  32'(ifa.fill_level),   32'(i + 1));
         check_val("a_fill_af",   32'(ifa.almost_full),  32'((i + 1) >= 6));
         check_val("a_fill_full", 32'(ifa.full),         32'((i + 1) == 8));
         check_val("a_fill_ae",   32'(ifa.almost_empty), 32'((i + 1) <= 2));
         check_val("a_fill_vld",  32'(ifa.rd_valid),     32'd0);
      end

      // Full with simultaneous write and read: the read wins, the write is rejected
      ifa.w_inc   = 1'b1;
      ifa.r_inc   = 1'b1;
      ifa.wr_data = 8'hEE;
      tick();
      ifa.w_inc = 1'b0;
      ifa.r_inc = 1'b0;
      check_val("a_wr_rd_full_lvl",  32'(ifa.fill_level), 32'd7);
      check_val("a_wr_rd_full_ovf",  32'(ifa.overflow),   32'd1);
      check_val("a_wr_rd_full_full", 32'(ifa.full),       32'd0);
      check_val("a_rd0_data",        32'(ifa.rd_data),    32'h11);
      check_val("a_rd0_vld",         32'(ifa.rd_valid),   32'd1);
      tick();
      check_val("a_idle_vld",  32'(ifa.rd_valid), 32'd0);
      check_val("a_idle_hold", 32'(ifa.rd_data),  32'h11);
      check_val("a_ovf_stick", 32'(ifa.overflow), 32'd1);
      ifa.clr_err = 1'b1;
      tick();
      ifa.clr_err = 1'b0;
      check_val("a_ovf_clr", 32'(ifa.overflow), 32'd0);

      // Drain the remaining seven; the rejected 0xEE must never appear
      for (int i = 1; i < 8; i++) begin
         ifa.r_inc = 1'b1;
         tick();
         check_val("a_rd_data", 32'(ifa.rd_data),    32'(8'h11 + i));
         check_val("a_rd_vld",  32'(ifa.rd_valid),   32'd1);
         check_val("a_rd_lvl",  32'(ifa.fill_level), 32'(7 - i));
      end
      ifa.r_inc = 1'b0;
      tick();
      check_val("a_drained_empty", 32'(ifa.empty),    32'd1);
      check_val("a_drained_vld",   32'(ifa.rd_valid), 32'd0);
      check_val("a_drained_hold",  32'(ifa.rd_data),  32'h18);

      // Level 4, then reset with a write pending
      for (int i = 0; i < 4; i++) begin
         ifa.w_inc   = 1'b1;
         ifa.wr_data = 8'(8'h40 + i);
         tick();
      end
      check_val("a_pre_rst_lvl", 32'(ifa.fill_level), 32'd4);
      ifa.wr_data = 8'h77;
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      ifa.w_inc = 1'b0;
      check_reset_a("a_midrst");
      ifa.r_inc = 1'b1;
      tick();
      ifa.r_inc = 1'b0;
      check_val("a_post_rst_udf", 32'(ifa.underflow),  32'd1);
      check_val("a_post_rst_lvl", 32'(ifa.fill_level), 32'd0);
      check_val("a_post_rst_vld", 32'(ifa.rd_valid),   32'd0);
      // Set and clear in the same cycle: the set wins
      ifa.r_inc   = 1'b1;
      ifa.clr_err = 1'b1;
      tick();
      ifa.r_inc = 1'b0;
      check_val("a_udf_set_wins", 32'(ifa.underflow), 32'd1);
      tick();
      ifa.clr_err = 1'b0;
      check_val("a_udf_clr", 32'(ifa.underflow), 32'd0);

      // ---------------- Instance B: FWFT, depth 5 ----------------
      ifb.w_inc   = 1'b1;
      ifb.r_inc   = 1'b1;
      ifb.wr_data = 8'hA5;
      tick();
      ifb.w_inc = 1'b0;
      ifb.r_inc = 1'b0;
      check_val("b_empty_rw_udf",  32'(ifb.underflow),  32'd1);
      check_val("b_empty_rw_lvl",  32'(ifb.fill_level), 32'd1);
      check_val("b_empty_rw_vld",  32'(ifb.rd_valid),   32'd1);
      check_val("b_empty_rw_data", 32'(ifb.rd_data),    32'hA5);
      ifb.clr_err = 1'b1;
      tick();
      ifb.clr_err = 1'b0;
      check_val("b_udf_clr",   32'(ifb.underflow), 32'd0);
      check_val("b_head_hold", 32'(ifb.rd_data),   32'hA5);
      ifb.r_inc = 1'b1;
      tick();
      ifb.r_inc = 1'b0;
      check_val("b_pop_empty", 32'(ifb.empty),    32'd1);
      check_val("b_pop_vld",   32'(ifb.rd_valid), 32'd0);

      // Twelve writes with reads trailing by two cycles; pointers wrap twice
      for (int c = 0; c < 14; c++) begin
         wr = (c < 12);
         rd = (c >= 2);
         ifb.w_inc   = wr;
         ifb.r_inc   = rd;
         ifb.wr_data = 8'(8'hB0 + c);
         if (rd) begin
            check_val("b_stag_head", 32'(ifb.rd_data),  32'(q[0]));
            check_val("b_stag_vld",  32'(ifb.rd_valid), 32'd1);
         end
         tick();
         if (rd) begin
            void'(q.pop_front());
         end
         if (wr) begin
            q.push_back(8'(8'hB0 + c));
         end
         check_val("b_stag_lvl", 32'(ifb.fill_level), 32'(q.size()));
      end
      ifb.w_inc = 1'b0;
      ifb.r_inc = 1'b0;
      check_val("b_stag_empty", 32'(ifb.empty), 32'd1);

      // Fill to five, then one more write overflows without disturbing the head
      for (int i = 0; i < 5; i++) begin
         ifb.w_inc   = 1'b1;
         ifb.wr_data = 8'(8'hC0 + i);
         tick();
         check_val("b_fill_af", 32'(ifb.almost_full), 32'((i + 1) >= 3));
      end
      check_val("b_fill_full", 32'(ifb.full),    32'd1);
      check_val("b_fill_head", 32'(ifb.rd_data), 32'hC0);
      ifb.wr_data = 8'hFF;
      tick();
      ifb.w_inc = 1'b0;
      check_val("b_ovf",      32'(ifb.overflow),   32'd1);
      check_val("b_ovf_lvl",  32'(ifb.fill_level), 32'd5);
      check_val("b_ovf_head", 32'(ifb.rd_data),    32'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
